spike_window_counter: RTL and testbench
=======================================

// Module: spike_window_counter
// PURPOSE
//  Digitises the spike train of the spikifier comparator output (q) into spike counts.
//  Counts rising edges of spike_in over back-to-back windows of window_len clk cycles.
//  Each count goes out on a valid/ready port to the downstream accumulator / readout.
//  Sits directly downstream of the spikifier, in the clk domain.
// PARAMETERS
//  CNT_W        12  width of spike count result (saturating)
//  WIN_W        16  width of window length / window cycle counter
//  SYNC_STAGES   2  flops in spike_in synchroniser (min 2)
// PORTS
//  clk         in   1      system clock, all logic on posedge
//  rst         in   1      synchronous, active-high reset
//  en          in   1      run windows while high
//  window_len  in   WIN_W  window length in clk cycles; latched at each window start
//  spike_in    in   1      spikifier q; async to clk, high pulses >= 1.5 clk periods
//  cnt_data    out  CNT_W  spike count of the completed window
//  cnt_sat     out  1      count in cnt_data saturated
//  cnt_valid   out  1      cnt_data/cnt_sat valid
//  cnt_ready   in   1      downstream accepts when cnt_valid && cnt_ready
//  overrun     out  1      sticky: a window result was dropped
//  busy        out  1      high in state COUNT
// BEHAVIOUR
//  Reset (rst high at posedge): all outputs 0, sync chain 0, FSM IDLE, counters 0.
//  Front end: SYNC_STAGES-flop synchroniser, then rising-edge detect -> 1-cycle pulse
//   spk_p. A spike_in rise is seen as spk_p SYNC_STAGES+1 cycles later (+/-1, metastab.).
//  FSM states IDLE, COUNT:
//   IDLE: en=1 -> COUNT, latch N = (window_len==0) ? 1 : window_len, win_cnt=0, acc=0.
//   COUNT: lasts exactly N cycles. Each cycle acc += spk_p (saturate at 2^CNT_W-1,
//    set sat flag if an increment is lost). win_cnt counts 0..N-1.
//   Last COUNT cycle (win_cnt==N-1): result = acc + spk_p (saturating). Same posedge:
//    result goes to output register (rule below). en=1 -> new window starts at once
//    (re-latch window_len, acc=0, no gap cycle). en=0 -> IDLE.
//   en=0 on a non-final COUNT cycle: window abandoned, no result, IDLE next cycle.
//  spk_p is counted in the window whose COUNT cycle it falls in. spk_p in IDLE is dropped.
//  Output register (1 deep):
//   cnt_valid rises the cycle after the final window cycle. cnt_data/cnt_sat are stable
//    while cnt_valid && !cnt_ready.
//   Handshake completes at posedge with cnt_valid && cnt_ready. cnt_valid then falls,
//    unless a new result loads on that same edge: new data, cnt_valid stays 1, no overrun.
//   New result while cnt_valid && !cnt_ready: new result dropped, old data kept,
//    overrun set to 1 and held until rst.
//  Widths: acc is CNT_W bits and never wraps. win_cnt is WIN_W bits, compared to N-1.
//  window_len changes mid-window take effect only at the next window start.
//  rst mid-window or mid-handshake: result discarded, cnt_valid drops next cycle.
// TESTING
//  1 N=10, en=1 held, 3 spikes 3 cycles wide inside window 1, cnt_ready=1
//    -> cnt_data=3, cnt_valid 1 cycle after cycle 10. Next window result 0.
//  2 N=4, cnt_ready=0, 1 spike per window -> first result held (cnt_data=1)
//    -> overrun=1 after window 2. Raise cnt_ready -> data 1 accepted, overrun stays 1.
//  3 CNT_W=4, N=200, 20 spikes -> cnt_data=15, cnt_sat=1. Next window 0 spikes -> 0, sat 0.
//  4 window_len=0, en=1, cnt_ready=1 -> cnt_valid every cycle (1-cycle windows).
//    A single spk_p is counted in exactly one window.
//  5 Drop en at cycle 5 of an N=10 window with 2 spikes -> no cnt_valid, busy=0.
//    IDLE next cycle.
//  6 Assert rst for 1 cycle mid-window and with cnt_valid=1 -> all outputs 0
//    the next cycle, overrun cleared. Restart gives correct counts.

Source files
------------

// File: rtl/spike_window_counter.sv
`default_nettype none
// ============================================================================
//  Module      : spike_window_counter
//  Description : Counts rising edges of an asynchronous spike train over
//                back-to-back windows and hands each count out on valid/ready.
//  Revision    : 1.0  initial release
// ============================================================================
module spike_window_counter #(
    parameter int CNT_W       = 12,
    parameter int WIN_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIN_W-1:0] window_len,
    input  logic             spike_in,
    output logic [CNT_W-1:0] cnt_data,
    output logic             cnt_sat,
    output logic             cnt_valid,
    input  logic             cnt_ready,
    output logic             overrun,
    output logic             busy
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [WIN_W-1:0] c_win_one = WIN_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   spk_prev_q, spk_prev_d;
    logic                   spk_p_q, spk_p_d;
    logic [WIN_W-1:0]       len_q, len_d;
    logic [WIN_W-1:0]       win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0]       acc_q, acc_d;
    logic                   sat_q, sat_d;
    logic [CNT_W-1:0]       cnt_data_q, cnt_data_d;
    logic                   cnt_sat_q, cnt_sat_d;
    logic                   cnt_valid_q, cnt_valid_d;
    logic                   overrun_q, overrun_d;

    logic [CNT_W:0]         acc_sum;
    logic [CNT_W-1:0]       acc_next;
    logic                   sat_next;
    logic [WIN_W-1:0]       len_new;
    logic                   win_last;
    logic                   result_load;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        win_cnt_d   = win_cnt_q;
        acc_d       = acc_q;
        sat_d       = sat_q;
        cnt_data_d  = cnt_data_q;
        cnt_sat_d   = cnt_sat_q;
        cnt_valid_d = cnt_valid_q;
        overrun_d   = overrun_q;
        result_load = 1'b0;

        // Synchroniser shifts toward the MSB; the MSB feeds the edge detector.
        sync_d     = {sync_q[SYNC_STAGES-2:0], spike_in};
        spk_prev_d = sync_q[SYNC_STAGES-1];
        spk_p_d    = sync_q[SYNC_STAGES-1] & ~spk_prev_q;

        // The carry bit flags an increment lost to saturation.
        acc_sum  = {1'b0, acc_q} + {{CNT_W{1'b0}}, spk_p_q};
        acc_next = acc_sum[CNT_W] ? c_cnt_max : acc_sum[CNT_W-1:0];
        sat_next = sat_q | acc_sum[CNT_W];

        len_new  = (window_len == '0) ? c_win_one : window_len;
        win_last = (win_cnt_q == (len_q - c_win_one));

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d   = ST_COUNT;
                    len_d     = len_new;
                    win_cnt_d = '0;
                    acc_d     = '0;
                    sat_d     = 1'b0;
                end
            end
            ST_COUNT: begin
                if (win_last) begin
                    result_load = 1'b1;
                    if (en) begin
                        len_d     = len_new;
                        win_cnt_d = '0;
                        acc_d     = '0;
                        sat_d     = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (!en) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d     = acc_next;
                    sat_d     = sat_next;
                    win_cnt_d = win_cnt_q + c_win_one;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A slot frees up on the same edge its handshake completes.
        if (result_load) begin
            if (!cnt_valid_q || cnt_ready) begin
                cnt_data_d  = acc_next;
                cnt_sat_d   = sat_next;
                cnt_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (cnt_valid_q && cnt_ready) begin
            cnt_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sync_q      <= '0;
            spk_prev_q  <= 1'b0;
            spk_p_q     <= 1'b0;
            len_q       <= '0;
            win_cnt_q   <= '0;
            acc_q       <= '0;
            sat_q       <= 1'b0;
            cnt_data_q  <= '0;
            cnt_sat_q   <= 1'b0;
            cnt_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            spk_prev_q  <= spk_prev_d;
            spk_p_q     <= spk_p_d;
            len_q       <= len_d;
            win_cnt_q   <= win_cnt_d;
            acc_q       <= acc_d;
            sat_q       <= sat_d;
            cnt_data_q  <= cnt_data_d;
            cnt_sat_q   <= cnt_sat_d;
            cnt_valid_q <= cnt_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign cnt_data  = cnt_data_q;
    assign cnt_sat   = cnt_sat_q;
    assign cnt_valid = cnt_valid_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q == ST_COUNT);

endmodule
`default_nettype wire

// File: tb/tb_spike_window_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spike_window_counter
//  Description : Self-checking bench for spike_window_counter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spike_window_counter;

    localparam int CNT_W       = 4;
    localparam int WIN_W       = 16;
    localparam int SYNC_STAGES = 2;
    localparam int LAT         = SYNC_STAGES + 1;
    localparam int CMAX        = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [WIN_W-1:0] window_len;
    logic             spike_in;
    logic [CNT_W-1:0] cnt_data;
    logic             cnt_sat;
    logic             cnt_valid;
    logic             cnt_ready;
    logic             overrun;
    logic             busy;

    spike_window_counter #(
        .CNT_W      (CNT_W),
        .WIN_W      (WIN_W),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .window_len(window_len),
        .spike_in  (spike_in),
        .cnt_data  (cnt_data),
        .cnt_sat   (cnt_sat),
        .cnt_valid (cnt_valid),
        .cnt_ready (cnt_ready),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: spike history, remaining window cycles, unbounded total.
    bit m_h [0:7];
    bit m_busy, m_valid, m_sat, m_ovr;
    int m_left, m_total, m_data;

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic model_edge();
        bit spk;
        bit load;
        int n_new;
        int res;
        if (rst) begin
            for (int i = 0; i < 8; i++) m_h[i] = 1'b0;
            m_busy = 0; m_left = 0; m_total = 0;
            m_valid = 0; m_data = 0; m_sat = 0; m_ovr = 0;
            return;
        end
        spk = m_h[LAT-1] & ~m_h[LAT];
        for (int i = 7; i > 0; i--) m_h[i] = m_h[i-1];
        m_h[0] = spike_in;
        n_new = (window_len == 0) ? 1 : int'(window_len);
        load  = 0;
        res   = 0;
        if (!m_busy) begin
            if (en) begin
                m_busy = 1; m_left = n_new; m_total = 0;
            end
        end else begin
            m_total += int'(spk);
            m_left--;
            if (m_left == 0) begin
                load = 1;
                res  = m_total;
                if (en) begin
                    m_left = n_new; m_total = 0;
                end else begin
                    m_busy = 0;
                end
            end else if (!en) begin
                m_busy = 0;
            end
        end
        if (load) begin
            if (!m_valid || cnt_ready) begin
                m_valid = 1;
                m_data  = (res > CMAX) ? CMAX : res;
                m_sat   = (res > CMAX);
            end else begin
                m_ovr = 1;
            end
        end else if (m_valid && cnt_ready) begin
            m_valid = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("cnt_valid", int'(cnt_valid), int'(m_valid));
        check("busy", int'(busy), int'(m_busy));
        check("overrun", int'(overrun), int'(m_ovr));
        if (m_valid) begin
            check("cnt_data", int'(cnt_data), m_data);
            check("cnt_sat", int'(cnt_sat), int'(m_sat));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; spike_in = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    typedef struct {
        int len;
        int nspk;
        int exp_cnt;
        int exp_sat;
    } row_t;

    row_t rows [6];

    initial begin
        int c;
        int vcount;
        int vsum;
        int hold;

        rows[0] = '{10, 3, 3, 0};
        rows[1] = '{200, 20, 15, 1};
        rows[2] = '{60, 15, 15, 0};
        rows[3] = '{60, 16, 15, 1};
        rows[4] = '{25, 1, 1, 0};
        rows[5] = '{12, 4, 4, 0};

        rst = 1'b1; en = 1'b0; window_len = '0; spike_in = 1'b0; cnt_ready = 1'b0;
        tick();
        tick();
        check("rst_valid", int'(cnt_valid), 0);
        check("rst_data", int'(cnt_data), 0);
        check("rst_sat", int'(cnt_sat), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b0;

        // Table: one spiked window then an empty one; 2-wide pulses every 3 cycles.
        foreach (rows[r]) begin
            cnt_ready = 1'b1;
            do_reset();
            en = 1'b1;
            window_len = WIN_W'(rows[r].len);
            c = 0;
            while (1) begin
                spike_in = ((c / 3) < rows[r].nspk) && ((c % 3) < 2);
                tick();
                if (cnt_valid || c > rows[r].len + 20) break;
                c++;
            end
            check($sformatf("row%0d_latency", r), c, rows[r].len);
            check($sformatf("row%0d_cnt", r), int'(cnt_data), rows[r].exp_cnt);
            check($sformatf("row%0d_sat", r), int'(cnt_sat), rows[r].exp_sat);
            spike_in = 1'b0;
            c++;
            tick();
            while (!cnt_valid && c <= 2 * rows[r].len + 20) begin
                c++;
                tick();
            end
            check($sformatf("row%0d_w2_latency", r), c, 2 * rows[r].len);
            check($sformatf("row%0d_w2_cnt", r), int'(cnt_data), 0);
            check($sformatf("row%0d_w2_sat", r), int'(cnt_sat), 0);
            en = 1'b0;
            tick();
        end

        // Stalled consumer: first result held, later ones dropped into overrun.
        cnt_ready = 1'b0;
        do_reset();
        en = 1'b1; window_len = WIN_W'(4);
        for (int i = 0; i < 14; i++) begin
            spike_in = ((i % 4) < 2);
            tick();
        end
        en = 1'b0; spike_in = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("stall_valid", int'(cnt_valid), 1);
        check("stall_data", int'(cnt_data), 1);
        check("stall_overrun", int'(overrun), 1);
        cnt_ready = 1'b1;
        tick();
        check("accept_valid", int'(cnt_valid), 0);
        check("accept_overrun", int'(overrun), 1);

        // One-cycle windows: a single spike is counted exactly once.
        cnt_ready = 1'b1;
        do_reset();
        en = 1'b1; window_len = '0;
        vcount = 0; vsum = 0;
        for (int i = 0; i < 12; i++) begin
            spike_in = (i < 3);
            tick();
            if (cnt_valid) begin
                vcount++;
                vsum += int'(cnt_data);
            end
        end
        check("len0_valid_cycles", vcount, 11);
        check("len0_spike_sum", vsum, 1);
        en = 1'b0;
        tick();

        // Abandoned window: en drops mid-window, no result ever appears.
        do_reset();
        en = 1'b1; window_len = WIN_W'(10);
        for (int i = 0; i < 5; i++) begin
            spike_in = ((i % 3) < 2);
            tick();
        end
        en = 1'b0; spike_in = 1'b0;
        tick();
        check("abandon_busy", int'(busy), 0);
        vcount = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (cnt_valid) vcount++;
        end
        check("abandon_no_valid", vcount, 0);

        // Reset mid-window while holding a result and a set overrun flag.
        cnt_ready = 1'b0;
        do_reset();
        en = 1'b1; window_len = WIN_W'(3);
        for (int i = 0; i < 11; i++) begin
            spike_in = ((i % 4) < 2);
            tick();
        end
        check("pre_rst_overrun", int'(overrun), 1);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", int'(cnt_valid), 0);
        check("mid_rst_data", int'(cnt_data), 0);
        check("mid_rst_sat", int'(cnt_sat), 0);
        check("mid_rst_overrun", int'(overrun), 0);
        check("mid_rst_busy", int'(busy), 0);
        rst = 1'b0; en = 1'b0; spike_in = 1'b0;
        tick();

        // Random traffic against the reference model.
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 299) == 0);
            en         = ($urandom_range(0, 19) != 0);
            window_len = WIN_W'($urandom_range(0, 12));
            cnt_ready  = ($urandom_range(0, 2) != 0);
            if (hold > 0) begin
                hold--;
            end else begin
                spike_in = 1'($urandom_range(0, 1));
                hold     = $urandom_range(1, 4);
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
